// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: shared constants and types for the UART-to-AES command sequencer
package aes_uart_pkg;
    localparam logic [7:0] CMD_KEY_DEF      = 8'h6B;
    localparam logic [7:0] CMD_PT_DEF       = 8'h70;
    localparam int         TIMEOUT_CLKS_DEF = 17360;

    typedef enum logic [1:0] {S_IDLE, S_RX_KEY, S_RX_PT, S_WAIT_AES} state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CMD     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;
endpackage

// File: rtl/byte_packer_128.sv
// byte_packer_128: assembles 16 bytes into a 128-bit block, first byte in [127:120]
//   i_Clock, i_Rst_n : clock, asynchronous active-low reset
//   i_Shift, i_Byte  : append i_Byte to the block
//   i_Clear          : restart the byte count
//   o_Block          : stored bytes plus the byte currently presented
//   o_Last           : the presented byte is the 16th of the frame
module byte_packer_128 (
    input  logic         i_Clock,
    input  logic         i_Rst_n,
    input  logic         i_Shift,
    input  logic         i_Clear,
    input  logic [7:0]   i_Byte,
    output logic [127:0] o_Block,
    output logic         o_Last
);
    // Only 15 bytes need storing: the 16th is consumed from i_Byte on the
    // completion edge, and the oldest byte is shifted out right after it.
    logic [119:0] shift;
    logic [3:0]   count;

    assign o_Block = {shift, i_Byte};
    assign o_Last  = count == 4'hF;

    always_ff @(posedge i_Clock or negedge i_Rst_n)
        if (!i_Rst_n) begin
            shift <= '0;
            count <= '0;
        end else if (i_Clear)
            count <= '0;
        else if (i_Shift) begin
            shift <= {shift[111:0], i_Byte};
            count <= count + 4'd1;
        end
endmodule

// File: rtl/uart_aes_cmd_ctrl.sv
// uart_aes_cmd_ctrl: parses UART command frames into AES key loads and encryption starts
//   i_Clock, i_Rst_n      : clock, asynchronous active-low reset
//   i_Rx_DV, i_Rx_Byte    : received byte with 1-cycle valid
//   i_Aes_Busy            : AES core busy, start held off while high
//   o_Key, o_Key_Load     : key register and its update pulse
//   o_Pt, o_Start         : plaintext register and encryption start pulse
//   o_Err, o_Err_Code     : error pulse and held code (01 cmd, 10 timeout, 11 overrun)
//   o_Busy                : a frame is in progress or waiting on the core
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_aes_cmd_ctrl
    import aes_uart_pkg::*;
#(
`ifdef UART_CMD_TIMEOUT_EN
    parameter int         TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
`endif
    parameter logic [7:0] CMD_KEY = CMD_KEY_DEF,
    parameter logic [7:0] CMD_PT  = CMD_PT_DEF
) (
    input  logic         i_Clock,
    input  logic         i_Rst_n,
    input  logic         i_Rx_DV,
    input  logic [7:0]   i_Rx_Byte,
    input  logic         i_Aes_Busy,
    output logic [127:0] o_Key,
    output logic         o_Key_Load,
    output logic [127:0] o_Pt,
    output logic         o_Start,
    output logic         o_Err,
    output logic [1:0]   o_Err_Code,
    output logic         o_Busy
);
    state_t       state;
    logic         rx;
    logic         expire;
    logic [127:0] block;
    logic         last;

    assign rx     = state == S_RX_KEY || state == S_RX_PT;
    assign o_Busy = state != S_IDLE;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] tmo_cnt;

    // Fires on the edge at which the counter would reach TIMEOUT_CLKS-1;
    // a byte on that same edge takes priority.
    assign expire = rx && !i_Rx_DV && tmo_cnt == TW'(TIMEOUT_CLKS - 2);

    always_ff @(posedge i_Clock or negedge i_Rst_n)
        if (!i_Rst_n)
            tmo_cnt <= '0;
        else
            tmo_cnt <= (!rx || i_Rx_DV || expire) ? '0 : tmo_cnt + 1'b1;
`else
    assign expire = 1'b0;
`endif

    byte_packer_128 u_packer (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Shift (rx && i_Rx_DV),
        .i_Clear (state == S_IDLE || expire),
        .i_Byte  (i_Rx_Byte),
        .o_Block (block),
        .o_Last  (last)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n)
        if (!i_Rst_n) begin
            state      <= S_IDLE;
            o_Key      <= '0;
            o_Pt       <= '0;
            o_Key_Load <= 1'b0;
            o_Start    <= 1'b0;
            o_Err      <= 1'b0;
            o_Err_Code <= ERR_NONE;
        end else begin
            o_Key_Load <= 1'b0;
            o_Start    <= 1'b0;
            o_Err      <= 1'b0;
            case (state)
                S_IDLE:
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == CMD_KEY)
                            state <= S_RX_KEY;
                        else if (i_Rx_Byte == CMD_PT)
                            state <= S_RX_PT;
                        else begin
                            o_Err      <= 1'b1;
                            o_Err_Code <= ERR_CMD;
                        end
                    end
                S_RX_KEY, S_RX_PT:
                    if (i_Rx_DV && last) begin
                        if (state == S_RX_KEY) begin
                            o_Key      <= block;
                            o_Key_Load <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            o_Pt    <= block;
                            o_Start <= !i_Aes_Busy;
                            state   <= i_Aes_Busy ? S_WAIT_AES : S_IDLE;
                        end
                    end else if (expire) begin
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_TIMEOUT;
                        state      <= S_IDLE;
                    end
                S_WAIT_AES: begin
                    // Bytes arriving while the block waits for the core are dropped.
                    if (i_Rx_DV) begin
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_OVERRUN;
                    end
                    if (!i_Aes_Busy) begin
                        o_Start <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_aes_cmd_ctrl.sv
// tb_uart_aes_cmd_ctrl: self-checking bench for uart_aes_cmd_ctrl
module tb_uart_aes_cmd_ctrl;
    localparam int TCLK = 17360;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] base;
        logic [7:0] step;
        bit         ld;
        bit         st;
        bit         er;
        logic [1:0] code;
    } vec_t;

    logic         i_Clock = 1'b0;
    logic         i_Rst_n = 1'b0;
    logic         i_Rx_DV = 1'b0;
    logic [7:0]   i_Rx_Byte = 8'h00;
    logic         i_Aes_Busy = 1'b0;
    logic [127:0] o_Key, o_Pt;
    logic         o_Key_Load, o_Start, o_Err, o_Busy;
    logic [1:0]   o_Err_Code;

    int passed = 0, total = 0;
    int n_load = 0, n_start = 0, n_err = 0;
    logic [127:0] m_key = '0, m_pt = '0;
    logic [1:0]   m_code = 2'b00;
    logic [7:0]   pl [16];

    uart_aes_cmd_ctrl dut (
        .i_Clock    (i_Clock),
        .i_Rst_n    (i_Rst_n),
        .i_Rx_DV    (i_Rx_DV),
        .i_Rx_Byte  (i_Rx_Byte),
        .i_Aes_Busy (i_Aes_Busy),
        .o_Key      (o_Key),
        .o_Key_Load (o_Key_Load),
        .o_Pt       (o_Pt),
        .o_Start    (o_Start),
        .o_Err      (o_Err),
        .o_Err_Code (o_Err_Code),
        .o_Busy     (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic tick();
        @(posedge i_Clock);
        #1;
        n_load  += int'(o_Key_Load);
        n_start += int'(o_Start);
        n_err   += int'(o_Err);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        tick();
        i_Rx_DV   = 1'b0;
    endtask

    task automatic send_payload(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            send_byte(pl[i]);
            if (i < last) repeat ($urandom_range(0, gap)) tick();
        end
    endtask

    // Frame value: payload byte i lands at bit position 8*(15-i).
    function automatic logic [127:0] pack();
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v[8*(15-i) +: 8] = pl[i];
        return v;
    endfunction

    task automatic rand_pl();
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    endtask

    initial begin
        vec_t vt [6];
        int b0, e0, bl, bs, be, sel;
        bit bz;
        logic [7:0] cmd;

        tick();
        tick();
        chk("reset_key", o_Key, '0);
        chk("reset_pt", o_Pt, '0);
        chki("reset_flags", int'({o_Key_Load, o_Start, o_Err, o_Busy, o_Err_Code}), 0);
        i_Rst_n = 1'b1;
        tick();

        vt[0] = '{8'h6B, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 2'b00};
        vt[1] = '{8'h70, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00};
        vt[2] = '{8'h41, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2'b01};
        vt[3] = '{8'h6B, 8'hA5, 8'h11, 1'b1, 1'b0, 1'b0, 2'b00};
        vt[4] = '{8'h70, 8'h6B, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00};
        vt[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2'b01};
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) pl[i] = vt[k].base + 8'(i) * vt[k].step;
            if (vt[k].er) m_code = vt[k].code;
            if (vt[k].cmd == 8'h6B) m_key = pack();
            if (vt[k].cmd == 8'h70) m_pt = pack();
            send_byte(vt[k].cmd);
            if (!vt[k].er) begin
                chki($sformatf("vec%0d_busy", k), int'(o_Busy), 1);
                send_payload(0, 15, 2);
            end
            chki($sformatf("vec%0d_load", k), int'(o_Key_Load), int'(vt[k].ld));
            chki($sformatf("vec%0d_start", k), int'(o_Start), int'(vt[k].st));
            chki($sformatf("vec%0d_err", k), int'(o_Err), int'(vt[k].er));
            chki($sformatf("vec%0d_code", k), int'(o_Err_Code), int'(m_code));
            chk($sformatf("vec%0d_key", k), o_Key, m_key);
            chk($sformatf("vec%0d_pt", k), o_Pt, m_pt);
            if (k == 0) chk("key_ramp", o_Key, 128'h000102030405060708090A0B0C0D0E0F);
            tick();
            chki($sformatf("vec%0d_idle", k), int'({o_Busy, o_Key_Load, o_Start, o_Err}), 0);
        end

        // Core busy: block waits, overrun byte is dropped, one start after release
        i_Aes_Busy = 1'b1;
        for (int i = 0; i < 16; i++) pl[i] = 8'(8'h30 + i);
        m_pt = pack();
        b0 = n_start;
        send_byte(8'h70);
        send_payload(0, 15, 0);
        chki("wait_busy", int'(o_Busy), 1);
        chki("wait_no_start", int'(o_Start), 0);
        chk("wait_pt", o_Pt, m_pt);
        repeat (10) tick();
        send_byte(8'h55);
        m_code = 2'b11;
        chki("ovr_err", int'(o_Err), 1);
        chki("ovr_code", int'(o_Err_Code), int'(m_code));
        chk("ovr_pt", o_Pt, m_pt);
        chki("ovr_busy", int'(o_Busy), 1);
        repeat (39) tick();
        chki("wait_held", n_start - b0, 0);
        i_Aes_Busy = 1'b0;
        tick();
        chki("wait_start", int'(o_Start), 1);
        tick();
        chki("wait_once", n_start - b0, 1);
        chki("wait_idle", int'(o_Busy), 0);

        // Back-to-back: command byte the cycle after completion
        for (int i = 0; i < 16; i++) pl[i] = 8'(i * 7);
        m_key = pack();
        send_byte(8'h6B);
        send_payload(0, 15, 0);
        chki("b2b_load", int'(o_Key_Load), 1);
        send_byte(8'h70);
        chki("b2b_accept", int'(o_Busy), 1);
        chki("b2b_noerr", int'(o_Err), 0);
        for (int i = 0; i < 16; i++) pl[i] = ~8'(i);
        m_pt = pack();
        send_payload(0, 15, 1);
        chki("b2b_start", int'(o_Start), 1);
        chk("b2b_pt", o_Pt, m_pt);
        chk("b2b_key", o_Key, m_key);
        tick();

        // Reset mid-frame
        rand_pl();
        send_byte(8'h6B);
        send_payload(0, 7, 0);
        #2 i_Rst_n = 1'b0;
        #1;
        chk("rst_key", o_Key, '0);
        chk("rst_pt", o_Pt, '0);
        chki("rst_flags", int'({o_Key_Load, o_Start, o_Err, o_Busy, o_Err_Code}), 0);
        m_key = '0;
        m_pt = '0;
        m_code = 2'b00;
        tick();
        i_Rst_n = 1'b1;
        tick();
        rand_pl();
        m_key = pack();
        send_byte(8'h6B);
        send_payload(0, 15, 0);
        chki("rst_fresh_load", int'(o_Key_Load), 1);
        chk("rst_fresh_key", o_Key, m_key);
        tick();

        // Partial frame followed by silence
        rand_pl();
        e0 = n_err;
        send_byte(8'h70);
        send_payload(0, 4, 0);
`ifdef UART_CMD_TIMEOUT_EN
        repeat (TCLK - 2) tick();
        chki("tmo_early", n_err - e0, 0);
        tick();
        m_code = 2'b10;
        chki("tmo_err", int'(o_Err), 1);
        chki("tmo_code", int'(o_Err_Code), int'(m_code));
        chki("tmo_idle", int'(o_Busy), 0);
        chk("tmo_pt", o_Pt, m_pt);
        tick();
        e0 = n_err;
        send_byte(8'h70);
        send_payload(0, 4, 0);
        repeat (TCLK - 2) tick();
        send_byte(pl[5]);
        chki("tmo_coincide_err", n_err - e0, 0);
        chki("tmo_coincide_busy", int'(o_Busy), 1);
        send_payload(6, 15, 0);
`else
        repeat (TCLK + 50) tick();
        chki("notmo_err", n_err - e0, 0);
        chki("notmo_busy", int'(o_Busy), 1);
        send_payload(5, 15, 0);
`endif
        m_pt = pack();
        chki("tail_start", int'(o_Start), 1);
        chk("tail_pt", o_Pt, m_pt);
        tick();

        // Randomized frames against the model
        for (int f = 0; f < 30; f++) begin
            sel = int'($urandom_range(0, 2));
            bz = 1'($urandom_range(0, 1));
            bl = n_load;
            bs = n_start;
            be = n_err;
            rand_pl();
            i_Aes_Busy = bz;
            if (sel == 2) begin
                do cmd = 8'($urandom); while (cmd == 8'h6B || cmd == 8'h70);
                send_byte(cmd);
                m_code = 2'b01;
            end else begin
                send_byte(sel == 1 ? 8'h70 : 8'h6B);
                send_payload(0, 15, 3);
                if (sel == 0) m_key = pack();
                else m_pt = pack();
                if (sel == 1 && bz) begin
                    chki($sformatf("rnd%0d_wait", f), int'(o_Busy), 1);
                    repeat ($urandom_range(1, 20)) tick();
                    i_Aes_Busy = 1'b0;
                    tick();
                end
            end
            i_Aes_Busy = 1'b0;
            tick();
            chki($sformatf("rnd%0d_loads", f), n_load - bl, int'(sel == 0));
            chki($sformatf("rnd%0d_starts", f), n_start - bs, int'(sel == 1));
            chki($sformatf("rnd%0d_errs", f), n_err - be, int'(sel == 2));
            chk($sformatf("rnd%0d_key", f), o_Key, m_key);
            chk($sformatf("rnd%0d_pt", f), o_Pt, m_pt);
            chki($sformatf("rnd%0d_code", f), int'(o_Err_Code), int'(m_code));
            chki($sformatf("rnd%0d_idle", f), int'(o_Busy), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
